imm_gen_pipe: RTL and testbench

Pipelined, XLEN-parametrised immediate generator for the decode stage. It accepts 32-bit instructions over a valid/ready handshake and emits a registered, sign- or zero-extended immediate, an immediate-format tag and an illegal flag one cycle later. A 2-entry skid buffer decouples fetch from execute backpressure. New relative to the prior combinational extender: RV64 support, shift-amount and CSR-zimm formats, illegal detection, a flush input, and registered handshaked output.

---
 rtl/imm_gen_pipe_pkg.sv | 29 ++
 rtl/imm_gen_pipe_if.sv | 25 ++
 rtl/imm_decode.sv | 60 ++++++
 rtl/imm_gen_pipe.sv | 78 +++++++
 tb/tb_imm_gen_pipe.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode and immediate-format types for the decode-stage immediate generator.
package imm_gen_pipe_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_FENCE  = 7'h0F,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_OP     = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle; master is the fetch/execute side.
interface imm_gen_pipe_if
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_fmt_e        out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational instruction-to-immediate decoder with format tag and illegal flag.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);
  localparam int SHAMT_W = $clog2(XLEN);

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_IMM: begin
        if (instr[13:12] == 2'b01) begin
          fmt = FMT_SH;
          // shamt[5] only exists on RV64
          if (XLEN == 32 && instr[25]) illegal = 1'b1;
          else imm = XLEN'(instr[20 +: SHAMT_W]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr[31:20]));
        end
      end
      OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(instr[31:20]));
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OP_SYSTEM: begin
        if (instr[14]) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end
      end
      OP_OP, OP_FENCE: ;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a 2-entry skid buffer (head drives outputs).
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if ($bits(bus.out_imm) != XLEN) begin : g_bad_if
    $error("imm_gen_pipe: interface XLEN does not match module XLEN");
  end

  logic [1:0]      count;
  logic [XLEN-1:0] dec_imm, head_imm, skid_imm;
  imm_fmt_e        dec_fmt, head_fmt, skid_fmt;
  logic            dec_ill, head_ill, skid_ill;
  logic            acc, ret;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  // Ready is a function of occupancy only, so backpressure never reaches fetch combinationally.
  assign bus.in_ready    = ~rst & (count != 2'd2);
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_imm     = head_imm;
  assign bus.out_fmt     = head_fmt;
  assign bus.out_illegal = head_ill;

  assign acc = bus.in_valid & bus.in_ready;
  assign ret = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      head_imm <= '0;
      head_fmt <= FMT_NONE;
      head_ill <= 1'b0;
      skid_imm <= '0;
      skid_fmt <= FMT_NONE;
      skid_ill <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (acc && !ret) begin
      if (count == 2'd0) begin
        head_imm <= dec_imm;
        head_fmt <= dec_fmt;
        head_ill <= dec_ill;
      end else begin
        skid_imm <= dec_imm;
        skid_fmt <= dec_fmt;
        skid_ill <= dec_ill;
      end
      count <= count + 2'd1;
    end else if (ret && !acc) begin
      if (count == 2'd2) begin
        head_imm <= skid_imm;
        head_fmt <= skid_fmt;
        head_ill <= skid_ill;
      end
      count <= count - 2'd1;
    end else if (acc && ret) begin
      // Count is 1 here (2 blocks accept); the new entry replaces the retiring head.
      head_imm <= dec_imm;
      head_fmt <= dec_fmt;
      head_ill <= dec_ill;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench with a scoreboard for XLEN=32 and direct checks for XLEN=64.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic acc_flag;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

  always #5 clk = ~clk;

  logic [31:0] s_instr [12] = '{32'hFFF00093, 32'hFE000EE3, 32'h12345037, 32'h02009093,
                                32'h3002D073, 32'h0000007F, 32'hFE000E23, 32'h0080006F,
                                32'h00208033, 32'h30001073, 32'h4030D093, 32'h00402083};
  logic [31:0] s_imm   [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0,
                                32'h5,        32'h0,        32'hFFFFFFFC, 32'h8,
                                32'h0,        32'h0,        32'h3,        32'h4};
  logic [2:0]  s_fmt   [12] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0, 3'd2, 3'd5, 3'd0, 3'd0, 3'd6, 3'd1};
  logic        s_ill   [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic [31:0] w_instr [4] = '{32'h80000037, 32'h02009093, 32'hFFF00093, 32'h3002D073};
  logic [63:0] w_imm   [4] = '{64'hFFFFFFFF80000000, 64'h20, 64'hFFFFFFFFFFFFFFFF, 64'h5};
  logic [2:0]  w_fmt   [4] = '{3'd4, 3'd6, 3'd1, 3'd7};

  function automatic exp_t mk(logic [63:0] imm, logic [2:0] fmt, logic ill);
    exp_t e;
    e.imm = imm;
    e.fmt = fmt;
    e.ill = ill;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the 32-bit DUT: compare against the model, then update the model.
  task automatic cycle();
    exp_t e;
    logic mvalid, mready;
    @(negedge clk);
    acc_flag = 1'b0;
    mvalid = (exp_q.size() != 0);
    mready = !rst && (exp_q.size() < 2);
    chk("out_valid", 64'(b32.out_valid), 64'(mvalid));
    chk("in_ready", 64'(b32.in_ready), 64'(mready));
    if (mvalid) begin
      e = exp_q[0];
      chk("out_imm", 64'(b32.out_imm), {32'b0, e.imm[31:0]});
      chk("out_fmt", 64'(b32.out_fmt), 64'(e.fmt));
      chk("out_illegal", 64'(b32.out_illegal), 64'(e.ill));
    end
    if (flush) begin
      exp_q.delete();
    end else begin
      if (mvalid && b32.out_ready) void'(exp_q.pop_front());
      if (b32.in_valid && mready) begin
        exp_q.push_back(cur);
        acc_flag = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] instr, exp_t e);
    b32.in_instr = instr;
    b32.in_valid = 1'b1;
    cur = e;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc_flag) break;
    end
    chk("send_accepted", 64'(acc_flag), 64'd1);
  endtask

  task automatic idle(int n);
    b32.in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.out_ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd0);
    chk("rst_out_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_out_fmt", 64'(b32.out_fmt), 64'(FMT_NONE));
    chk("rst_out_illegal", 64'(b32.out_illegal), 64'd0);
    chk("rst64_out_valid", 64'(b64.out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream with consumer always ready.
    for (int i = 0; i < 12; i++)
      send(s_instr[i], mk({32'b0, s_imm[i]}, s_fmt[i], s_ill[i]));
    idle(3);

    // Backpressure: A,B fill the buffer, C waits for space.
    b32.out_ready = 1'b0;
    send(32'h12345037, mk(64'h12345000, FMT_U, 1'b0));
    send(32'hFE000EE3, mk(64'hFFFFFFFC, FMT_B, 1'b0));
    b32.in_instr = 32'hFFF00093;
    cur = mk(64'hFFFFFFFF, FMT_I, 1'b0);
    repeat (3) cycle();
    b32.out_ready = 1'b1;
    send(32'hFFF00093, mk(64'hFFFFFFFF, FMT_I, 1'b0));
    idle(4);

    // Flush a full buffer while a new instruction is offered.
    b32.out_ready = 1'b0;
    send(32'h0080006F, mk(64'h8, FMT_J, 1'b0));
    send(32'h3002D073, mk(64'h5, FMT_Z, 1'b0));
    b32.in_instr = 32'hFE000E23;
    cur = mk(64'hFFFFFFFC, FMT_S, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle(2);

    // Asynchronous reset with a full buffer.
    send(32'h12345037, mk(64'h12345000, FMT_U, 1'b0));
    send(32'hFFF00093, mk(64'hFFFFFFFF, FMT_I, 1'b0));
    b32.in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(b32.in_ready), 64'd0);
    chk("async_rst_out_imm", 64'(b32.out_imm), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    b32.out_ready = 1'b1;
    idle(2);

    // RV64 variant: one instruction at a time.
    for (int i = 0; i < 4; i++) begin
      b64.in_instr = w_instr[i];
      b64.in_valid = 1'b1;
      @(negedge clk);
      chk("rv64_in_ready", 64'(b64.in_ready), 64'd1);
      @(posedge clk);
      #1 b64.in_valid = 1'b0;
      @(negedge clk);
      chk("rv64_out_valid", 64'(b64.out_valid), 64'd1);
      chk("rv64_out_imm", b64.out_imm, w_imm[i]);
      chk("rv64_out_fmt", 64'(b64.out_fmt), 64'(w_fmt[i]));
      chk("rv64_out_illegal", 64'(b64.out_illegal), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rv64_drained", 64'(b64.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
